// File: rtl/unlock_key_sequencer_if.sv
// Key-word transfer port of unlock_key_sequencer: valid/ready handshake carrying one key word.
interface unlock_key_sequencer_if #(
  parameter int unsigned KEY_W = 8
);
  logic             key_valid;
  logic [KEY_W-1:0] key_data;
  logic             key_ready;

  modport master (output key_valid, output key_data, input key_ready);
  modport slave  (input key_valid, input key_data, output key_ready);
endinterface

// File: rtl/unlock_key_sequencer.sv
// Power-on lock unlock sequencer: checks a NUM_WORDS-word key, escalates repeated failures to lockout.
// Optional macro UNLOCK_LOCKOUT_TIMER_EN: lockout expires after LOCKOUT_CYCLES instead of lasting until reset.
module unlock_key_sequencer #(
  parameter int unsigned KEY_W          = 8,
  parameter int unsigned NUM_WORDS      = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned WORD_TIMEOUT   = 16,
  parameter int unsigned LOCKOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  unlock_key_sequencer_if.slave            key,
  input  logic [NUM_WORDS*KEY_W-1:0]       key_ref,
  input  logic                             relock,
  output logic                             unlock,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic                             lockout
);

  localparam int unsigned IDX_W = $clog2(NUM_WORDS);
  localparam int unsigned FC_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TM_W  = $clog2(WORD_TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [FC_W-1:0]  MAX_FC   = FC_W'(MAX_FAILS);
  localparam logic [TM_W-1:0]  TM_LAST  = TM_W'(WORD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_UNLOCKED,
    S_LOCKOUT
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             mismatch;
  logic [TM_W-1:0]  timer;

`ifdef UNLOCK_LOCKOUT_TIMER_EN
  localparam int unsigned LC_W = $clog2(LOCKOUT_CYCLES + 1);
  logic [LC_W-1:0] lk_cnt;
`endif

  logic            transfer;
  logic            word_miss;
  logic            attempt_miss;
  logic            done;
  logic            failed;
  logic [FC_W-1:0] fail_next;

  always_comb begin
    transfer     = key.key_valid & key.key_ready;
    word_miss    = (key.key_data != key_ref[idx*KEY_W +: KEY_W]);
    attempt_miss = mismatch | word_miss;
    fail_next    = (fail_count == MAX_FC) ? MAX_FC : fail_count + 1'b1;
    done         = 1'b0;
    failed       = 1'b0;
    // A last-word transfer takes priority over a timeout landing in the same cycle
    if (state == S_COLLECT) begin
      if (transfer) begin
        if (idx == LAST_IDX) begin
          done   = 1'b1;
          failed = attempt_miss;
        end
      end else if (timer == TM_LAST) begin
        done   = 1'b1;
        failed = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      key.key_ready <= 1'b0;
      unlock        <= 1'b0;
      fail_count    <= '0;
      lockout       <= 1'b0;
      idx           <= '0;
      mismatch      <= 1'b0;
      timer         <= '0;
`ifdef UNLOCK_LOCKOUT_TIMER_EN
      lk_cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          key.key_ready <= 1'b1;
          if (transfer) begin
            idx      <= IDX_W'(1);
            mismatch <= word_miss;
            timer    <= '0;
            state    <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (done) begin
            // Decision cycle: ready drops whatever the outcome
            key.key_ready <= 1'b0;
            idx           <= '0;
            mismatch      <= 1'b0;
            timer         <= '0;
            if (!failed) begin
              unlock     <= 1'b1;
              fail_count <= '0;
              state      <= S_UNLOCKED;
            end else begin
              fail_count <= fail_next;
              if (fail_next == MAX_FC) begin
                lockout <= 1'b1;
                state   <= S_LOCKOUT;
`ifdef UNLOCK_LOCKOUT_TIMER_EN
                lk_cnt  <= LC_W'(LOCKOUT_CYCLES);
`endif
              end else begin
                state <= S_IDLE;
              end
            end
          end else if (transfer) begin
            idx      <= idx + 1'b1;
            mismatch <= attempt_miss;
            timer    <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_UNLOCKED: begin
          key.key_ready <= 1'b0;
          if (relock) begin
            unlock        <= 1'b0;
            key.key_ready <= 1'b1;
            state         <= S_IDLE;
          end
        end

        S_LOCKOUT: begin
          key.key_ready <= 1'b0;
`ifdef UNLOCK_LOCKOUT_TIMER_EN
          if (lk_cnt == LC_W'(1)) begin
            lockout       <= 1'b0;
            fail_count    <= MAX_FC - 1'b1;
            key.key_ready <= 1'b1;
            state         <= S_IDLE;
          end else begin
            lk_cnt <= lk_cnt - 1'b1;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unlock_key_sequencer.sv
// Self-checking bench for unlock_key_sequencer: directed steps with random key data and gaps,
// checked against an attempt-level model (whole-key compare, failure counter, lockout flag).
module tb_unlock_key_sequencer;

  localparam int unsigned KEY_W        = 8;
  localparam int unsigned NUM_WORDS    = 4;
  localparam int unsigned MAX_FAILS    = 3;
  localparam int unsigned WORD_TIMEOUT = 16;
  localparam int unsigned LOCKOUT_CYC  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] key_ref = 32'hA53C960F;
  logic        relock;
  logic        unlock;
  logic [1:0]  fail_count;
  logic        lockout;

  int checks = 0;
  int errors = 0;

  // Attempt-level reference state
  int exp_fails = 0;
  bit exp_lock  = 1'b0;
  bit exp_unl   = 1'b0;

  unlock_key_sequencer_if #(.KEY_W(KEY_W)) kif ();

  unlock_key_sequencer #(
    .KEY_W(KEY_W),
    .NUM_WORDS(NUM_WORDS),
    .MAX_FAILS(MAX_FAILS),
    .WORD_TIMEOUT(WORD_TIMEOUT),
    .LOCKOUT_CYCLES(LOCKOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(kif),
    .key_ref(key_ref),
    .relock(relock),
    .unlock(unlock),
    .fail_count(fail_count),
    .lockout(lockout)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Idle for gap cycles, then hold one word until accepted (bounded wait)
  task automatic send_word(input logic [7:0] w, input int gap);
    int budget;
    kif.key_valid = 1'b0;
    tick(gap);
    kif.key_valid = 1'b1;
    kif.key_data  = w;
    budget = 64;
    while (!kif.key_ready && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) check("ready_wait", 32'd0, 32'd1);
    tick(1);
    kif.key_valid = 1'b0;
    kif.key_data  = $urandom;
  endtask

  task automatic send_attempt(input logic [31:0] words, input int g1, input int g2, input int g3);
    send_word(words[7:0], 0);
    send_word(words[15:8], g1);
    send_word(words[23:16], g2);
    send_word(words[31:24], g3);
  endtask

  task automatic model_result(input bit ok);
    if (ok) begin
      exp_unl   = 1'b1;
      exp_fails = 0;
    end else begin
      exp_fails = (exp_fails + 1 > int'(MAX_FAILS)) ? int'(MAX_FAILS) : exp_fails + 1;
      exp_lock  = (exp_fails == int'(MAX_FAILS));
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_unlock"}, unlock, exp_unl);
    check({tag, "_fails"}, fail_count, exp_fails);
    check({tag, "_lockout"}, lockout, exp_lock);
  endtask

  task automatic attempt(input string tag, input logic [31:0] words, input int g1, input int g2, input int g3);
    send_attempt(words, g1, g2, g3);
    model_result(words == key_ref);
    check_outputs(tag);
    check({tag, "_ready_decide"}, kif.key_ready, 1'b0);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick(1);
    relock = 1'b0;
    exp_unl = 1'b0;
    check("relock_unlock", unlock, 1'b0);
    check("relock_ready", kif.key_ready, 1'b1);
  endtask

  task automatic async_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    exp_unl = 1'b0; exp_fails = 0; exp_lock = 1'b0;
    check_outputs(tag);
    check({tag, "_ready"}, kif.key_ready, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(1);
  endtask

  function automatic logic [31:0] wrong_key();
    logic [31:0] k;
    if ($urandom_range(1, 0) == 1) begin
      k = $urandom;
      if (k == key_ref) k = k ^ 32'h1;
    end else begin
      k = key_ref ^ (32'(8'($urandom_range(255, 1))) << (8 * $urandom_range(3, 0)));
    end
    return k;
  endfunction

  initial begin
    logic [31:0] k;
    int lk_edges;
    reset = 1'b1;
    relock = 1'b0;
    kif.key_valid = 1'b0;
    kif.key_data = '0;

    // Reset values
    tick(2);
    check_outputs("reset");
    check("reset_ready", kif.key_ready, 1'b0);
    reset = 1'b0;
    check("first_cycle_ready", kif.key_ready, 1'b0);
    tick(1);
    check("idle_ready", kif.key_ready, 1'b1);

    // Correct key back-to-back, then ready/unlock hold while a stray word is offered
    attempt("good1", key_ref, 0, 0, 0);
    kif.key_valid = 1'b1;
    kif.key_data = 8'h0F;
    tick(5);
    kif.key_valid = 1'b0;
    check("unlocked_hold", unlock, 1'b1);
    check("unlocked_ready", kif.key_ready, 1'b0);
    do_relock();
    relock = 1'b1;
    tick(1);
    relock = 1'b0;
    check("relock_idle_ignored", unlock, 1'b0);
    attempt("good2", key_ref, 0, 0, 0);
    do_relock();

    // Wrong first word still consumes four words
    attempt("bad_first", 32'hA53C9600, 0, 0, 0);
    tick(1);
    check("after_fail_ready", kif.key_ready, 1'b1);

    // Word timeout: 15 idle cycles tolerated, the 16th fails the attempt
    send_word(8'h0F, 0);
    send_word(8'h96, 0);
    tick(WORD_TIMEOUT - 1);
    check("timeout_edge_fails", fail_count, exp_fails);
    tick(1);
    model_result(1'b0);
    check_outputs("timeout");
    check("timeout_ready", kif.key_ready, 1'b0);
    attempt("restart_word0", key_ref, 0, 0, 0);
    do_relock();

    // Last word arriving exactly at the timeout boundary completes the attempt
    attempt("boundary_last", key_ref, 3, 7, WORD_TIMEOUT - 1);
    do_relock();

    // Random attempts with random gaps, never reaching lockout here
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1 || exp_fails == int'(MAX_FAILS) - 1) k = key_ref;
      else k = wrong_key();
      attempt("rand", k, $urandom_range(WORD_TIMEOUT - 1, 0), $urandom_range(WORD_TIMEOUT - 1, 0),
              $urandom_range(WORD_TIMEOUT - 1, 0));
      if (exp_unl) do_relock();
    end

    // Escalate into lockout; a correct key is then ignored
    while (!exp_lock) attempt("to_lockout", wrong_key(), $urandom_range(4, 0), 0, $urandom_range(4, 0));
    lk_edges = 0;
    kif.key_valid = 1'b1;
    kif.key_data = 8'h0F;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      lk_edges++;
      check("lockout_ready", kif.key_ready, 1'b0);
      check("lockout_unlock", unlock, 1'b0);
    end
    kif.key_valid = 1'b0;
    check_outputs("lockout_hold");

`ifdef UNLOCK_LOCKOUT_TIMER_EN
    tick(int'(LOCKOUT_CYC) - 1 - lk_edges);
    check("lockout_before_expiry", lockout, 1'b1);
    tick(1);
    exp_lock = 1'b0;
    exp_fails = int'(MAX_FAILS) - 1;
    check_outputs("lockout_expired");
    check("expired_ready", kif.key_ready, 1'b1);
    attempt("relock_fail", wrong_key(), 0, 0, 0);
`endif

    // Asynchronous reset: in lockout, mid-attempt with failures recorded, and while unlocked
    async_reset("rst_lockout");
    attempt("pre_mid", wrong_key(), 0, 0, 0);
    send_word(8'h0F, 1);
    send_word(8'h96, 0);
    async_reset("rst_mid");
    attempt("after_mid", key_ref, 0, 0, 0);
    async_reset("rst_unlocked");
    attempt("final", key_ref, 2, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
